fft_butterfly_pipe: RTL and testbench

- Pipelined radix-2 DIT complex butterfly: y_N = x_N + w*x_M, y_M = x_N - w*x_M.
- Full complex multiply with Q1.(TW_WIDTH-1) twiddles, rounding, optional per-sample scale-by-2, inverse (conjugate-twiddle) mode and saturation.
- Valid/ready handshake with backpressure.
- Sits between the FFT stage address generator/twiddle ROM and the stage memory. Successor to the current single-multiply butterfly.

---
 rtl/fft_pkg.sv | 55 +++++
 rtl/fft_butterfly_pipe_if.sv | 39 +++
 rtl/fft_cmul_pipe.sv | 158 +++++++++++++++
 rtl/fft_butterfly_pipe.sv | 114 +++++++++++
 tb/tb_fft_butterfly_pipe.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared types, constants and fixed-point helpers for the radix-2 butterfly.
//   cplx_t / twid_t : packed {im, re} complex samples and twiddles at the
//                     default widths.
//   acc_t           : wide signed working type. Every intermediate value is
//                     carried in it, so the helpers work for any width.
//   round_shift()   : (v + 2^(sh-1)) >>> sh, i.e. round half up.
//   sat_trunc()     : clamp v to the signed range of a w-bit number.
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int TW_WIDTH_DEF   = 16;
  localparam int BFLY_LATENCY   = 4;
  localparam int ACC_W          = 64;

  typedef struct packed {
    logic signed [DATA_WIDTH_DEF-1:0] im;
    logic signed [DATA_WIDTH_DEF-1:0] re;
  } cplx_t;

  typedef struct packed {
    logic signed [TW_WIDTH_DEF-1:0] im;
    logic signed [TW_WIDTH_DEF-1:0] re;
  } twid_t;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t ACC_ONE = 64'sd1;

  // Round half up, then drop the low sh bits (sh must be at least 1).
  function automatic acc_t round_shift(input acc_t v, input int unsigned sh);
    acc_t bias;
    bias = ACC_ONE <<< (sh - 32'd1);
    return (v + bias) >>> sh;
  endfunction

  // Clamp to [-2^(w-1), 2^(w-1)-1]. The caller detects clipping by comparing
  // the result with the input.
  function automatic acc_t sat_trunc(input acc_t v, input int unsigned w);
    acc_t hi;
    acc_t lo;
    hi = (ACC_ONE <<< (w - 32'd1)) - ACC_ONE;
    lo = ~hi;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fft_butterfly_pipe_if.sv
// -----------------------------------------------------------------------------
// fft_butterfly_pipe_if
// Bundles the butterfly's input/output handshakes, data buses and the sticky
// overflow flag.
//   master : the side that supplies samples and consumes results.
//   slave  : the butterfly itself.
// Signals: in_valid/in_ready, x_N, x_M, w_N, scale, inverse (input side);
//          out_valid/out_ready, y_N, y_M (output side); ovf, ovf_clr.
// -----------------------------------------------------------------------------
interface fft_butterfly_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [2*DATA_WIDTH-1:0] x_N;
  logic [2*DATA_WIDTH-1:0] x_M;
  logic [2*TW_WIDTH-1:0]   w_N;
  logic                    scale;
  logic                    inverse;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*DATA_WIDTH-1:0] y_N;
  logic [2*DATA_WIDTH-1:0] y_M;
  logic                    ovf;
  logic                    ovf_clr;

  modport master (
    output in_valid, x_N, x_M, w_N, scale, inverse, out_ready, ovf_clr,
    input  in_ready, out_valid, y_N, y_M, ovf
  );

  modport slave (
    input  in_valid, x_N, x_M, w_N, scale, inverse, out_ready, ovf_clr,
    output in_ready, out_valid, y_N, y_M, ovf
  );

endinterface

// File: rtl/fft_cmul_pipe.sv
// -----------------------------------------------------------------------------
// fft_cmul_pipe
// Three-stage pipelined complex multiply t = w * x_b (or conj(w) * x_b),
// rounded back to data scale. The upper operand x_a and the scale flag ride
// along so they arrive together with t.
//   clk, rst_n     : clock, synchronous active-low reset (valid bits only)
//   ce             : pipeline advance; all stages hold while low
//   in_valid       : sample present at the input
//   x_a, x_b, w    : {im, re} upper operand, lower operand, twiddle
//   scale_in       : carried through to scale_out
//   inverse_in     : use the conjugate twiddle
//   out_valid      : a, t and scale outputs are valid
//   a_out          : delayed x_a
//   t_re, t_im     : rounded product, DATA_WIDTH+2 bits signed
//   scale_out      : delayed scale flag
// -----------------------------------------------------------------------------
module fft_cmul_pipe
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TW_WIDTH   = TW_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic [2*DATA_WIDTH-1:0]      x_a,
  input  logic [2*DATA_WIDTH-1:0]      x_b,
  input  logic [2*TW_WIDTH-1:0]        w,
  input  logic                         scale_in,
  input  logic                         inverse_in,
  output logic                         out_valid,
  output logic [2*DATA_WIDTH-1:0]      a_out,
  output logic signed [DATA_WIDTH+1:0] t_re,
  output logic signed [DATA_WIDTH+1:0] t_im,
  output logic                         scale_out
);

  localparam int PW = DATA_WIDTH + TW_WIDTH;
  localparam int TOW = DATA_WIDTH + 2;
  localparam logic signed [TW_WIDTH-1:0] TW_MIN = {1'b1, {(TW_WIDTH-1){1'b0}}};
  localparam logic signed [TW_WIDTH-1:0] TW_MAX = {1'b0, {(TW_WIDTH-1){1'b1}}};

  logic signed [DATA_WIDTH-1:0] xb_re_s, xb_im_s;
  logic signed [TW_WIDTH-1:0]   w_re_s, w_im_s, w_im_eff_s;

  // Stage 1 registers
  logic                         s1_valid_d, s1_valid_q;
  logic [2*DATA_WIDTH-1:0]      s1_a_d, s1_a_q;
  logic signed [DATA_WIDTH-1:0] s1_xr_d, s1_xr_q, s1_xi_d, s1_xi_q;
  logic signed [TW_WIDTH-1:0]   s1_wr_d, s1_wr_q, s1_wi_d, s1_wi_q;
  logic                         s1_scale_d, s1_scale_q;

  // Stage 2 registers
  logic                         s2_valid_d, s2_valid_q;
  logic [2*DATA_WIDTH-1:0]      s2_a_d, s2_a_q;
  logic signed [PW-1:0]         s2_rr_d, s2_rr_q, s2_ii_d, s2_ii_q;
  logic signed [PW-1:0]         s2_ri_d, s2_ri_q, s2_ir_d, s2_ir_q;
  logic                         s2_scale_d, s2_scale_q;

  // Stage 3 registers
  logic                         s3_valid_d, s3_valid_q;
  logic [2*DATA_WIDTH-1:0]      s3_a_d, s3_a_q;
  logic signed [TOW-1:0]        s3_tr_d, s3_tr_q, s3_ti_d, s3_ti_q;
  logic                         s3_scale_d, s3_scale_q;

  acc_t tr_sum_s, ti_sum_s, tr_rnd_s, ti_rnd_s;

  assign xb_re_s = x_b[DATA_WIDTH-1:0];
  assign xb_im_s = x_b[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_re_s  = w[TW_WIDTH-1:0];
  assign w_im_s  = w[2*TW_WIDTH-1:TW_WIDTH];

  // Conjugate twiddle: negating the most negative code would wrap, so it
  // saturates to the most positive code instead.
  always_comb begin
    if (!inverse_in) begin
      w_im_eff_s = w_im_s;
    end else if (w_im_s == TW_MIN) begin
      w_im_eff_s = TW_MAX;
    end else begin
      w_im_eff_s = -w_im_s;
    end
  end

  // Stage 3 arithmetic: combine partial products and round to data scale.
  always_comb begin
    tr_sum_s = acc_t'(s2_rr_q) - acc_t'(s2_ii_q);
    ti_sum_s = acc_t'(s2_ri_q) + acc_t'(s2_ir_q);
    tr_rnd_s = round_shift(tr_sum_s, TW_WIDTH - 1);
    ti_rnd_s = round_shift(ti_sum_s, TW_WIDTH - 1);
  end

  // Next-state for all stages: load on ce, otherwise hold.
  always_comb begin
    s1_valid_d = ce ? in_valid   : s1_valid_q;
    s1_a_d     = ce ? x_a        : s1_a_q;
    s1_xr_d    = ce ? xb_re_s    : s1_xr_q;
    s1_xi_d    = ce ? xb_im_s    : s1_xi_q;
    s1_wr_d    = ce ? w_re_s     : s1_wr_q;
    s1_wi_d    = ce ? w_im_eff_s : s1_wi_q;
    s1_scale_d = ce ? scale_in   : s1_scale_q;

    s2_valid_d = ce ? s1_valid_q : s2_valid_q;
    s2_a_d     = ce ? s1_a_q     : s2_a_q;
    s2_rr_d    = ce ? (PW'(s1_xr_q) * PW'(s1_wr_q)) : s2_rr_q;
    s2_ii_d    = ce ? (PW'(s1_xi_q) * PW'(s1_wi_q)) : s2_ii_q;
    s2_ri_d    = ce ? (PW'(s1_xr_q) * PW'(s1_wi_q)) : s2_ri_q;
    s2_ir_d    = ce ? (PW'(s1_xi_q) * PW'(s1_wr_q)) : s2_ir_q;
    s2_scale_d = ce ? s1_scale_q : s2_scale_q;

    s3_valid_d = ce ? s2_valid_q     : s3_valid_q;
    s3_a_d     = ce ? s2_a_q         : s3_a_q;
    s3_tr_d    = ce ? TOW'(tr_rnd_s) : s3_tr_q;
    s3_ti_d    = ce ? TOW'(ti_rnd_s) : s3_ti_q;
    s3_scale_d = ce ? s2_scale_q     : s3_scale_q;
  end

  // Valid bits: the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
    end
  end

  // Data registers: qualified by the valid bits, so no reset is needed.
  always_ff @(posedge clk) begin
    s1_a_q     <= s1_a_d;
    s1_xr_q    <= s1_xr_d;
    s1_xi_q    <= s1_xi_d;
    s1_wr_q    <= s1_wr_d;
    s1_wi_q    <= s1_wi_d;
    s1_scale_q <= s1_scale_d;
    s2_a_q     <= s2_a_d;
    s2_rr_q    <= s2_rr_d;
    s2_ii_q    <= s2_ii_d;
    s2_ri_q    <= s2_ri_d;
    s2_ir_q    <= s2_ir_d;
    s2_scale_q <= s2_scale_d;
    s3_a_q     <= s3_a_d;
    s3_tr_q    <= s3_tr_d;
    s3_ti_q    <= s3_ti_d;
    s3_scale_q <= s3_scale_d;
  end

  assign out_valid = s3_valid_q;
  assign a_out     = s3_a_q;
  assign t_re      = s3_tr_q;
  assign t_im      = s3_ti_q;
  assign scale_out = s3_scale_q;

endmodule

// File: rtl/fft_butterfly_pipe.sv
// -----------------------------------------------------------------------------
// fft_butterfly_pipe
// Pipelined radix-2 DIT butterfly: y_N = x_N + w*x_M, y_M = x_N - w*x_M,
// with optional per-sample halving, conjugate-twiddle (inverse) mode,
// saturation and a sticky overflow flag. Four register stages; one
// sample per clock when the output is not stalled.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : slave side of fft_butterfly_pipe_if (handshakes, data, ovf)
// -----------------------------------------------------------------------------
module fft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TW_WIDTH   = TW_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_butterfly_pipe_if.slave  bus
);

  logic                         ce_s;
  logic                         cm_valid_s;
  logic [2*DATA_WIDTH-1:0]      cm_a_s;
  logic signed [DATA_WIDTH+1:0] cm_t_re_s, cm_t_im_s;
  logic                         cm_scale_s;
  logic signed [DATA_WIDTH-1:0] a_re_s, a_im_s;

  acc_t       sum_s [4];
  acc_t       scl_s [4];
  acc_t       sat_s [4];
  logic [3:0] clip_s;
  logic       s4_load_s;
  logic       ovf_set_s;

  logic                    out_valid_d, out_valid_q;
  logic [2*DATA_WIDTH-1:0] y_n_d, y_n_q;
  logic [2*DATA_WIDTH-1:0] y_m_d, y_m_q;
  logic                    ovf_d, ovf_q;

  // The whole pipeline moves whenever the output register is empty or being
  // drained; bubbles travel with it rather than being squeezed out.
  assign ce_s = ~out_valid_q | bus.out_ready;

  fft_cmul_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .TW_WIDTH   (TW_WIDTH)
  ) u_cmul (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce_s),
    .in_valid   (bus.in_valid),
    .x_a        (bus.x_N),
    .x_b        (bus.x_M),
    .w          (bus.w_N),
    .scale_in   (bus.scale),
    .inverse_in (bus.inverse),
    .out_valid  (cm_valid_s),
    .a_out      (cm_a_s),
    .t_re       (cm_t_re_s),
    .t_im       (cm_t_im_s),
    .scale_out  (cm_scale_s)
  );

  assign a_re_s = cm_a_s[DATA_WIDTH-1:0];
  assign a_im_s = cm_a_s[2*DATA_WIDTH-1:DATA_WIDTH];

  // Output stage arithmetic: add/subtract, optional rounded halving, clamp.
  // Order of components is {N.re, N.im, M.re, M.im}.
  always_comb begin
    sum_s[0] = acc_t'(a_re_s) + acc_t'(cm_t_re_s);
    sum_s[1] = acc_t'(a_im_s) + acc_t'(cm_t_im_s);
    sum_s[2] = acc_t'(a_re_s) - acc_t'(cm_t_re_s);
    sum_s[3] = acc_t'(a_im_s) - acc_t'(cm_t_im_s);
    for (int i = 0; i < 4; i++) begin
      scl_s[i]  = cm_scale_s ? round_shift(sum_s[i], 32'd1) : sum_s[i];
      sat_s[i]  = sat_trunc(scl_s[i], DATA_WIDTH);
      clip_s[i] = (sat_s[i] != scl_s[i]);
    end
  end

  // Output register next-state; ovf set takes priority over clear, and the
  // clear acts even while the pipeline is stalled.
  always_comb begin
    s4_load_s   = ce_s & cm_valid_s;
    ovf_set_s   = s4_load_s & (|clip_s);
    out_valid_d = ce_s ? cm_valid_s : out_valid_q;
    y_n_d       = s4_load_s ? {DATA_WIDTH'(sat_s[1]), DATA_WIDTH'(sat_s[0])} : y_n_q;
    y_m_d       = s4_load_s ? {DATA_WIDTH'(sat_s[3]), DATA_WIDTH'(sat_s[2])} : y_m_q;
    ovf_d       = ovf_set_s ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);
  end

  // Output register and sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_n_q       <= '0;
      y_m_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      y_n_q       <= y_n_d;
      y_m_q       <= y_m_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = ce_s;
  assign bus.out_valid = out_valid_q;
  assign bus.y_N       = y_n_q;
  assign bus.y_M       = y_m_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// -----------------------------------------------------------------------------
// tb_fft_butterfly_pipe
// Self-checking bench: a vector table of hand-computed butterflies, directed
// reset / ovf race sequences, and streamed random traffic scored against an
// integer-arithmetic reference of the butterfly.
// -----------------------------------------------------------------------------
module tb_fft_butterfly_pipe;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_butterfly_pipe_if #(.DATA_WIDTH(16), .TW_WIDTH(16)) bus ();

  fft_butterfly_pipe #(.DATA_WIDTH(16), .TW_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int xnr, xni, xmr, xmi, wr, wi;
    bit sc, inv;
    int ynr, yni, ymr, ymi;
    bit ovf;
  } vec_t;

  typedef struct {
    int ynr, yni, ymr, ymi;
    bit clip;
  } res_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  res_t        exp_q [$];
  bit          mon_on = 1'b0;
  bit          exp_ovf;
  bit          stall_pend;
  bit          accepted;
  logic [31:0] held_yn, held_ym;
  int          pops;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int re_of(input logic [31:0] v);
    return int'($signed(v[15:0]));
  endfunction

  function automatic int im_of(input logic [31:0] v);
    return int'($signed(v[31:16]));
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Reference butterfly in plain integer arithmetic: exact products,
  // floor((t + 2^14) / 2^15) rounding, floor((s + 1) / 2) halving, clamp.
  function automatic res_t model(input int xnr, xni, xmr, xmi, wr, wi,
                                 input bit sc, inv);
    longint wie, tr, ti;
    longint s [4];
    res_t r;
    wie = inv ? ((wi == -32768) ? 64'sd32767 : -longint'(wi)) : longint'(wi);
    tr = (longint'(xmr) * wr - longint'(xmi) * wie + 64'sd16384) >>> 15;
    ti = (longint'(xmr) * wie + longint'(xmi) * wr + 64'sd16384) >>> 15;
    s[0] = xnr + tr; s[1] = xni + ti; s[2] = xnr - tr; s[3] = xni - ti;
    r.clip = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (sc) s[k] = (s[k] + 1) >>> 1;
      if (s[k] > 32767) begin s[k] = 32767; r.clip = 1'b1; end
      else if (s[k] < -32768) begin s[k] = -32768; r.clip = 1'b1; end
    end
    r.ynr = int'(s[0]); r.yni = int'(s[1]); r.ymr = int'(s[2]); r.ymi = int'(s[3]);
    return r;
  endfunction

  task automatic drive(input int xnr, xni, xmr, xmi, wr, wi, input bit sc, inv);
    bus.x_N     = {16'(xni), 16'(xnr)};
    bus.x_M     = {16'(xmi), 16'(xmr)};
    bus.w_N     = {16'(wi), 16'(wr)};
    bus.scale   = sc;
    bus.inverse = inv;
  endtask

  // Scoreboard step, run mid-cycle while inputs and outputs are stable.
  task automatic monitor();
    res_t r;
    accepted = 1'b0;
    if (mon_on) begin
      check("in_ready_eq_ce", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (stall_pend) begin
        check("stall_hold_valid", bus.out_valid, 1);
        check("stall_hold_yN", bus.y_N, held_yn);
        check("stall_hold_yM", bus.y_M, held_ym);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_output: got an output, expected none");
        end else begin
          r = exp_q.pop_front();
          exp_ovf = exp_ovf | r.clip;
          check("stream_yN_re", re_of(bus.y_N), r.ynr);
          check("stream_yN_im", im_of(bus.y_N), r.yni);
          check("stream_yM_re", re_of(bus.y_M), r.ymr);
          check("stream_yM_im", im_of(bus.y_M), r.ymi);
          check("stream_ovf", bus.ovf, exp_ovf);
          pops++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(re_of(bus.x_N), im_of(bus.x_N), re_of(bus.x_M),
                              im_of(bus.x_M), re_of(bus.w_N), im_of(bus.w_N),
                              bus.scale, bus.inverse));
        accepted = 1'b1;
      end
      stall_pend = bus.out_valid && !bus.out_ready;
      held_yn = bus.y_N;
      held_ym = bus.y_M;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ovf();
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  // Streamed traffic. mode 0: 8-style back-to-back with out_ready 1,0,0,1.
  // mode 1: random valid/ready gaps and full-range random data.
  task automatic stream(input int n, input int mode, input int budget);
    int sent, cyc;
    bit have;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    clear_ovf();
    exp_ovf = 1'b0; stall_pend = 1'b0; pops = 0; exp_q.delete();
    sent = 0; cyc = 0; have = 1'b0;
    mon_on = 1'b1;
    while (pops < n && cyc < budget) begin
      if (sent < n && !have) begin
        drive(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(),
              ($urandom_range(0, 7) == 0) ? -32768 : rnd16(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        have = 1'b1;
      end
      bus.in_valid  = have && (mode == 0 || $urandom_range(0, 3) != 0);
      bus.out_ready = (mode == 0) ? pat[cyc % 4] : ($urandom_range(0, 2) != 0);
      tick();
      if (accepted) begin
        have = 1'b0;
        sent++;
      end
      cyc++;
    end
    mon_on = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count", pops, n);
    check("stream_leftover", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    int lat;
    bit seen;
    //          xnr    xni  xmr     xmi     wr      wi  sc inv  ynr    yni    ymr     ymi  ovf
    vecs[0] = '{50,    20,  100,    0,      0, -32768, 0, 0,  50,   -80,   50,    120,   0};
    vecs[1] = '{50,    20,  100,    0,      0, -32768, 0, 1,  50,   120,   50,    -80,   0};
    vecs[2] = '{0,     0,   3,      0,  16384,      0, 0, 0,  2,    0,     -2,    0,     0};
    vecs[3] = '{0,     0,   -3,     0,  16384,      0, 0, 0,  -1,   0,     1,     0,     0};
    vecs[4] = '{1,     -1,  0,      0,      0,      0, 1, 0,  1,    0,     1,     0,     0};
    vecs[5] = '{10,    10,  0,      100,    0,  16384, 0, 1,  60,   10,    -40,   10,    0};
    vecs[6] = '{32767, 0,   32767,  0,  32767,      0, 1, 0,  32767, 0,    1,     0,     0};
    vecs[7] = '{0,     0,   -32768, -32768, -32768, 0, 0, 0,  32767, 32767, -32768, -32768, 1};
    vecs[8] = '{-32768, 0,  32767,  0,  32767,      0, 0, 0,  -2,   0,     -32768, 0,     1};
    vecs[9] = '{32767, 0,   32767,  0,  32767,      0, 0, 0,  32767, 0,    1,     0,     1};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.ovf_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    tick(); tick();
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_yN", bus.y_N, 0);
    check("reset_yM", bus.y_M, 0);
    check("reset_ovf", bus.ovf, 0);
    check("reset_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    tick();

    // Vector table: one isolated sample each, ovf cleared beforehand.
    for (int i = 0; i < NV; i++) begin
      clear_ovf();
      drive(vecs[i].xnr, vecs[i].xni, vecs[i].xmr, vecs[i].xmi,
            vecs[i].wr, vecs[i].wi, vecs[i].sc, vecs[i].inv);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), lat, BFLY_LATENCY);
      check($sformatf("vec%0d_yN_re", i), re_of(bus.y_N), vecs[i].ynr);
      check($sformatf("vec%0d_yN_im", i), im_of(bus.y_N), vecs[i].yni);
      check($sformatf("vec%0d_yM_re", i), re_of(bus.y_M), vecs[i].ymr);
      check($sformatf("vec%0d_yM_im", i), im_of(bus.y_M), vecs[i].ymi);
      check($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].ovf);
      tick();
    end
    check("ovf_sticky_after_drain", bus.ovf, 1);

    // Reset with three samples in flight (ovf is still set from above).
    for (int i = 0; i < 3; i++) begin
      drive(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_yN", bus.y_N, 0);
    check("midrst_yM", bus.y_M, 0);
    check("midrst_ovf", bus.ovf, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst_no_stale_output", seen, 0);
    drive(vecs[0].xnr, vecs[0].xni, vecs[0].xmr, vecs[0].xmi,
          vecs[0].wr, vecs[0].wi, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("postrst_latency", lat, BFLY_LATENCY);
    check("postrst_yN_im", im_of(bus.y_N), -80);
    check("postrst_yM_im", im_of(bus.y_M), 120);
    tick();

    // Back-to-back with out_ready 1,0,0,1, then random traffic.
    stream(8, 0, 200);
    stream(300, 1, 4000);

    // Clear with nothing landing, then clear racing a clipping sample.
    clear_ovf();
    check("ovf_clear", bus.ovf, 0);
    bus.out_ready = 1'b1;
    drive(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("race_out_valid", bus.out_valid, 1);
    check("race_set_wins", bus.ovf, 1);
    tick();
    check("race_ovf_sticky", bus.ovf, 1);
    clear_ovf();
    check("race_then_clear", bus.ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
